// File: rtl/rsa_modexp_decrypt.sv
// RSA decryption core: m = c^d mod n by right-to-left square-and-multiply over a bit-serial modular multiplier.
// Define MODEXP_CONST_TIME_EN for fixed-latency operation (WIDTH loop iterations, multiply always performed).
module rsa_modexp_decrypt #(
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] n,
  output logic [WIDTH-1:0] m,
  output logic             busy,
  output logic             flag,
  output logic             err
);

  localparam int BW  = $clog2(WIDTH);
  localparam int ITW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {S_IDLE, S_REDUCE, S_LOOP, S_MUL_R, S_MUL_B, S_DONE} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_c, r_n, r_exp, r_base, r_result, r_m;
  logic [WIDTH:0]   r_acc;
  logic [BW-1:0]    r_bit;
  logic             r_bad, r_busy, r_flag, r_err;
`ifdef MODEXP_CONST_TIME_EN
  logic [ITW-1:0]   r_iter;
`endif

  logic [WIDTH-1:0] w_a, w_b;
  logic [WIDTH:0]   w_n_ext, w_t0, w_t1, w_t2, w_t3;
  logic             w_last;

  // Multiplier operands: a must already be reduced below n; b is scanned MSB first.
  always_comb begin
    w_a = r_base;
    w_b = r_base;
    case (r_state)
      S_REDUCE: begin w_a = WIDTH'(1); w_b = r_c; end
      S_MUL_R:  w_a = r_result;
      default:  ;
    endcase
  end

  // acc < n, so doubling never loses its top bit and every partial sum fits WIDTH+1 bits.
  assign w_n_ext = {1'b0, r_n};
  assign w_t0    = {r_acc[WIDTH-1:0], 1'b0};
  assign w_t1    = (w_t0 >= w_n_ext) ? w_t0 - w_n_ext : w_t0;
  assign w_t2    = w_t1 + (w_b[r_bit] ? {1'b0, w_a} : '0);
  assign w_t3    = (w_t2 >= w_n_ext) ? w_t2 - w_n_ext : w_t2;
  assign w_last  = (r_bit == '0);

  assign m    = r_m;
  assign busy = r_busy;
  assign flag = r_flag;
  assign err  = r_err;

  // NOTE: all state uses non-blocking assignments so every register updates from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_c      <= '0;
      r_n      <= '0;
      r_exp    <= '0;
      r_base   <= '0;
      r_result <= '0;
      r_m      <= '0;
      r_acc    <= '0;
      r_bit    <= '0;
      r_bad    <= 1'b0;
      r_busy   <= 1'b0;
      r_flag   <= 1'b0;
      r_err    <= 1'b0;
`ifdef MODEXP_CONST_TIME_EN
      r_iter   <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_c      <= c;
            r_n      <= n;
            r_exp    <= d;
            r_result <= WIDTH'(1);
            r_acc    <= '0;
            r_bit    <= BW'(WIDTH - 1);
            r_bad    <= 1'b0;
            r_err    <= 1'b0;
            r_busy   <= 1'b1;
`ifdef MODEXP_CONST_TIME_EN
            r_iter   <= '0;
`endif
            r_state  <= S_REDUCE;
          end
        end

        S_REDUCE, S_MUL_R, S_MUL_B: begin
          if (r_state == S_REDUCE && r_n < WIDTH'(2)) begin
            // Degenerate modulus: skip the arithmetic and report through LOOP.
            r_bad    <= 1'b1;
            r_result <= '0;
            r_state  <= S_LOOP;
          end else if (!w_last) begin
            r_acc <= w_t3;
            r_bit <= r_bit - BW'(1);
          end else begin
            r_acc <= '0;
            r_bit <= BW'(WIDTH - 1);
            case (r_state)
              S_REDUCE: begin
                r_base  <= w_t3[WIDTH-1:0];
                r_state <= S_LOOP;
              end
              S_MUL_R: begin
`ifdef MODEXP_CONST_TIME_EN
                if (r_exp[0]) r_result <= w_t3[WIDTH-1:0];
`else
                r_result <= w_t3[WIDTH-1:0];
`endif
                r_state <= S_MUL_B;
              end
              default: begin
                r_base  <= w_t3[WIDTH-1:0];
                r_exp   <= r_exp >> 1;
`ifdef MODEXP_CONST_TIME_EN
                r_iter  <= r_iter + ITW'(1);
`endif
                r_state <= S_LOOP;
              end
            endcase
          end
        end

        S_LOOP: begin
`ifdef MODEXP_CONST_TIME_EN
          if (r_bad || r_iter == ITW'(WIDTH)) begin
`else
          if (r_bad || r_exp == '0) begin
`endif
            r_m     <= r_result;
            r_err   <= r_bad;
            r_flag  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_DONE;
`ifdef MODEXP_CONST_TIME_EN
          end else begin
            r_state <= S_MUL_R;
          end
`else
          end else if (r_exp[0]) begin
            r_state <= S_MUL_R;
          end else begin
            r_state <= S_MUL_B;
          end
`endif
        end

        S_DONE: begin
          r_flag  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rsa_modexp_decrypt.sv
// Scoreboard bench for rsa_modexp_decrypt: expected m/err/latency queued at start, compared at flag.
module tb_rsa_modexp_decrypt;

  localparam int WIDTH = 12;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [WIDTH-1:0] c = '0, d = '0, n = '0;
  logic [WIDTH-1:0] m;
  logic             busy, flag, err;

  typedef struct {
    int unsigned m;
    int unsigned err;
    int unsigned lat;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  rsa_modexp_decrypt #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .start(start), .c(c), .d(d), .n(n),
    .m(m), .busy(busy), .flag(flag), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  function automatic exp_t model(input int unsigned cc, input int unsigned dd, input int unsigned nn);
    exp_t        e;
    int unsigned r, b, len, pop;
    if (nn < 2) begin
      e.m = 0; e.err = 1; e.lat = 2;
      return e;
    end
    r = 1; b = cc % nn; len = 0; pop = 0;
    for (int i = 0; i < WIDTH; i++) begin
      if ((dd >> i) & 1) begin
        r = (r * b) % nn;
        pop++;
        len = i + 1;
      end
      b = (b * b) % nn;
    end
    e.m = r; e.err = 0;
`ifdef MODEXP_CONST_TIME_EN
    e.lat = WIDTH * (1 + 2 * WIDTH) + WIDTH + 1;
`else
    e.lat = WIDTH * (1 + pop + len) + len + 1;
`endif
    return e;
  endfunction

  task automatic run_op(input logic [WIDTH-1:0] cc, input logic [WIDTH-1:0] dd,
                        input logic [WIDTH-1:0] nn, input bit disturb);
    exp_t e;
    int   lat, busy_bad;
    q.push_back(model(cc, dd, nn));
    @(negedge clk);
    c = cc; d = dd; n = nn; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 0; busy_bad = 0;
    while (lat < 2000) begin
      @(posedge clk);
      lat++;
      #1;
      if (flag) break;
      if (busy !== 1'b1) busy_bad++;
      if (disturb && lat < 40) begin
        start = lat[0];
        c = WIDTH'($urandom); d = WIDTH'($urandom); n = WIDTH'($urandom);
      end else if (disturb) begin
        start = 1'b0;
      end
    end
    e = q.pop_front();
    check("latency", lat, e.lat);
    check("m", m, e.m);
    check("err", err, e.err);
    check("busy_at_flag", busy, 0);
    check("busy_between", busy_bad, 0);
    @(posedge clk);
    #1 check("flag_pulse", flag, 0);
  endtask

  initial begin
    int flag_seen;
    repeat (3) @(posedge clk);
    #1;
    check("rst_m", m, 0);
    check("rst_busy", busy, 0);
    check("rst_flag", flag, 0);
    check("rst_err", err, 0);
    @(negedge clk) rst = 1'b0;

    run_op(12'd31,   12'd7,    12'd33,   1'b0);
    run_op(12'd31,   12'd1,    12'd33,   1'b0);
    run_op(12'd70,   12'd1,    12'd33,   1'b0);
    run_op(12'd5,    12'd0,    12'd33,   1'b0);
    run_op(12'd2,    12'd4092, 12'd4093, 1'b0);
    run_op(12'd4095, 12'd4095, 12'd4095, 1'b0);
    run_op(12'd66,   12'd5,    12'd33,   1'b0);
    run_op(12'd123,  12'd456,  12'd1,    1'b0);
    run_op(12'd9,    12'd3,    12'd0,    1'b0);
    run_op(12'd31,   12'd7,    12'd33,   1'b0);
    run_op(12'd31,   12'd7,    12'd33,   1'b1);

    // Abort mid-operation with reset, then confirm a clean restart.
    @(negedge clk);
    c = 12'd31; d = 12'd7; n = 12'd33; start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (20) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_m", m, 0);
    check("abort_busy", busy, 0);
    check("abort_flag", flag, 0);
    check("abort_err", err, 0);
    @(negedge clk) rst = 1'b0;
    flag_seen = 0;
    repeat (100) begin
      @(posedge clk);
      #1 if (flag) flag_seen++;
    end
    check("abort_no_flag", flag_seen, 0);
    run_op(12'd31, 12'd7, 12'd33, 1'b0);

    for (int i = 0; i < 4; i++)
      run_op(WIDTH'($urandom), WIDTH'($urandom), WIDTH'($urandom_range(4095, 2)), 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
